main_memory_responder: RTL and testbench

Backing-memory model that sits on the memory side of the set-associative cache and answers its line-refill reads.
- Accepts a read request (read_en plus byte address on memory_in) and waits a fixed, parameterised latency.
- Returns the addressed 32-bit word on memory_out with a one-cycle mem_valid strobe.
- A preload write port lets benches and the boot path seed contents; unwritten words return a deterministic address pattern.

---
 rtl/mem_resp_pkg.sv | 22 ++
 rtl/backing_store_ram.sv | 43 ++++
 rtl/main_memory_responder.sv | 105 ++++++++++
 tb/tb_main_memory_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and address helpers for the cache-side backing memory model.
package mem_resp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Full word address; callers keep only the low index bits, so upper bits alias.
  function automatic logic [ADDR_W-3:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

  function automatic logic [DATA_W-1:0] default_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/backing_store_ram.sv
// Word array with per-word written flags; unwritten words read back as their own address.
module backing_store_ram
  import mem_resp_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  written_q;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign wr_idx = IDX_W'(word_idx(wr_addr));
  assign rd_idx = IDX_W'(word_idx(rd_addr));

  // Data is never cleared; reset only drops the written flags.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written_q <= '0;
    end else if (wr_en) begin
      written_q[wr_idx] <= 1'b1;
    end
  end

  assign rd_data = written_q[rd_idx] ? mem_q[rd_idx] : default_word(rd_addr);

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency read responder for cache line refills, with a preload write port.
module main_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_en,
  input  logic [31:0]      memory_in,
  output logic [31:0]      memory_out,
  output logic             mem_valid,
  output logic             mem_busy,
  input  logic             wr_en,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  output logic [CNT_W-1:0] served_cnt
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        lat_q, lat_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rd_addr;
  logic [31:0]       rd_data;

  // In IDLE the request address is not captured yet, so look up the live input.
  assign rd_addr = (state_q == IDLE) ? memory_in : addr_q;

  backing_store_ram #(
    .IDX_W (IDX_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (read_en) begin
          addr_d = memory_in;
          lat_d  = LAT_M1;
          if (LATENCY == 1) begin
            state_d = RESP;
            out_d   = rd_data;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_q == 4'd1) begin
          state_d = RESP;
          out_d   = rd_data;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      addr_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign memory_out = out_q;
  assign mem_valid  = (state_q == RESP);
  assign mem_busy   = (state_q != IDLE);
  assign served_cnt = cnt_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench: one responder at LATENCY=3, one at LATENCY=1.
module tb_main_memory_responder;

  logic        clk;
  logic        rst;

  logic        a_read_en, a_wr_en, a_mem_valid, a_mem_busy;
  logic [31:0] a_memory_in, a_memory_out, a_wr_addr, a_wr_data;
  logic [15:0] a_served_cnt;

  logic        b_read_en, b_wr_en, b_mem_valid, b_mem_busy;
  logic [31:0] b_memory_in, b_memory_out, b_wr_addr, b_wr_data;
  logic [15:0] b_served_cnt;

  int total;
  int bad;

  main_memory_responder #(
    .LATENCY (3),
    .IDX_W   (8),
    .CNT_W   (16)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .read_en    (a_read_en),
    .memory_in  (a_memory_in),
    .memory_out (a_memory_out),
    .mem_valid  (a_mem_valid),
    .mem_busy   (a_mem_busy),
    .wr_en      (a_wr_en),
    .wr_addr    (a_wr_addr),
    .wr_data    (a_wr_data),
    .served_cnt (a_served_cnt)
  );

  main_memory_responder #(
    .LATENCY (1),
    .IDX_W   (8),
    .CNT_W   (16)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .read_en    (b_read_en),
    .memory_in  (b_memory_in),
    .memory_out (b_memory_out),
    .mem_valid  (b_mem_valid),
    .mem_busy   (b_mem_busy),
    .wr_en      (b_wr_en),
    .wr_addr    (b_wr_addr),
    .wr_data    (b_wr_data),
    .served_cnt (b_served_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [31:0] addr, input logic [31:0] data);
    a_wr_en   = 1'b1;
    a_wr_addr = addr;
    a_wr_data = data;
    tick();
    a_wr_en = 1'b0;
  endtask

  // Request sampled at E0; mem_valid must be seen only after E2, the edge entering RESP.
  task automatic rd_a(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    a_read_en   = 1'b1;
    a_memory_in = addr;
    tick();
    a_read_en = 1'b0;
    chk({tag, "_busy0"}, 32'(a_mem_busy), 32'd1);
    chk({tag, "_v0"}, 32'(a_mem_valid), 32'd0);
    tick();
    chk({tag, "_v1"}, 32'(a_mem_valid), 32'd0);
    tick();
    chk({tag, "_v2"}, 32'(a_mem_valid), 32'd1);
    chk({tag, "_data"}, a_memory_out, exp);
    tick();
    chk({tag, "_v3"}, 32'(a_mem_valid), 32'd0);
    chk({tag, "_idle"}, 32'(a_mem_busy), 32'd0);
    chk({tag, "_hold"}, a_memory_out, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    a_read_en = 1'b0; a_memory_in = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    b_read_en = 1'b0; b_memory_in = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    repeat (2) tick();

    chk("rst_a_valid", 32'(a_mem_valid), 32'd0);
    chk("rst_a_busy", 32'(a_mem_busy), 32'd0);
    chk("rst_a_out", a_memory_out, 32'h0);
    chk("rst_a_cnt", 32'(a_served_cnt), 32'd0);
    chk("rst_b_valid", 32'(b_mem_valid), 32'd0);
    chk("rst_b_out", b_memory_out, 32'h0);
    rst = 1'b0;
    tick();

    rd_a(32'h0000_1461, 32'h0000_1460, "unwritten");
    chk("cnt_after_first", 32'(a_served_cnt), 32'd1);

    wr_a(32'h0000_512D, 32'hCAFE_F00D);
    rd_a(32'h0000_512D, 32'hCAFE_F00D, "preload");
    rd_a(32'h0000_512F, 32'hCAFE_F00D, "same_word");

    rd_a(32'h0000_8863, 32'h0000_8860, "alias_unwritten");
    wr_a(32'h0000_1461, 32'h1122_3344);
    rd_a(32'h0000_8863, 32'h1122_3344, "alias_written");
    chk("cnt_after_alias", 32'(a_served_cnt), 32'd5);

    // Write landing in WAIT (at E1) is visible to the response.
    a_read_en = 1'b1; a_memory_in = 32'h0000_F257;
    tick();
    a_read_en = 1'b0;
    a_wr_en = 1'b1; a_wr_addr = 32'h0000_F257; a_wr_data = 32'hA5A5_A5A5;
    tick();
    a_wr_en = 1'b0;
    tick();
    chk("wr_wait_valid", 32'(a_mem_valid), 32'd1);
    chk("wr_wait_data", a_memory_out, 32'hA5A5_A5A5);
    tick();

    // Write on the edge entering RESP (E2) is not visible to that response.
    a_read_en = 1'b1; a_memory_in = 32'h0000_F257;
    tick();
    a_read_en = 1'b0;
    tick();
    a_wr_en = 1'b1; a_wr_addr = 32'h0000_F257; a_wr_data = 32'h5A5A_5A5A;
    tick();
    a_wr_en = 1'b0;
    chk("wr_resp_valid", 32'(a_mem_valid), 32'd1);
    chk("wr_resp_data", a_memory_out, 32'hA5A5_A5A5);
    tick();
    rd_a(32'h0000_F257, 32'h5A5A_5A5A, "wr_resp_later");
    chk("cnt_before_rst", 32'(a_served_cnt), 32'd8);

    // Asynchronous reset while WAITing abandons the request.
    a_read_en = 1'b1; a_memory_in = 32'h0000_512D;
    tick();
    a_read_en = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_out", a_memory_out, 32'h0);
    chk("midrst_cnt", 32'(a_served_cnt), 32'd0);
    chk("midrst_busy", 32'(a_mem_busy), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_novalid", 32'(a_mem_valid), 32'd0);
    end
    rd_a(32'h0000_512D, 32'h0000_512C, "rst_invalidates");
    chk("cnt_after_rst", 32'(a_served_cnt), 32'd1);

    // read_en pulses while busy are dropped, not queued.
    a_read_en = 1'b1; a_memory_in = 32'h0000_7D6B;
    tick();
    a_memory_in = 32'h0000_1111;
    tick();
    a_read_en = 1'b0;
    tick();
    chk("ign_valid", 32'(a_mem_valid), 32'd1);
    chk("ign_data", a_memory_out, 32'h0000_7D68);
    a_read_en = 1'b1;
    tick();
    a_read_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ign_noextra", 32'(a_mem_valid), 32'd0);
    end
    chk("ign_cnt", 32'(a_served_cnt), 32'd2);

    // LATENCY=1 with read_en held: responses two cycles apart.
    b_read_en = 1'b1; b_memory_in = 32'h0000_7D6B;
    tick();
    chk("b2b_v0", 32'(b_mem_valid), 32'd1);
    chk("b2b_d0", b_memory_out, 32'h0000_7D68);
    chk("b2b_busy0", 32'(b_mem_busy), 32'd1);
    b_memory_in = 32'h0000_8863;
    tick();
    chk("b2b_gap", 32'(b_mem_valid), 32'd0);
    chk("b2b_gap_hold", b_memory_out, 32'h0000_7D68);
    tick();
    b_read_en = 1'b0;
    chk("b2b_v1", 32'(b_mem_valid), 32'd1);
    chk("b2b_d1", b_memory_out, 32'h0000_8860);
    tick();
    chk("b2b_end", 32'(b_mem_valid), 32'd0);
    chk("b2b_cnt", 32'(b_served_cnt), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
